// File: rtl/dir_controller_p.sv
// Full-map directory controller: one entry per line (tag, data, DI/DS/DM state, sharer vector).
// Serialises coherence requests and issues replies, fetches and invalidations over a valid/ready channel.
module dir_controller_p #(
  parameter int NPROC  = 2,
  parameter int LINES  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int SRC_W  = (NPROC > 1) ? $clog2(NPROC) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [SRC_W-1:0]  req_src,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_op,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [NPROC-1:0]  rsp_dst,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_WB    = 2'd2;

  localparam logic [2:0] RSP_REPLY     = 3'd0;
  localparam logic [2:0] RSP_FETCH     = 3'd1;
  localparam logic [2:0] RSP_INV       = 3'd2;
  localparam logic [2:0] RSP_FETCH_INV = 3'd3;
  localparam logic [2:0] RSP_NACK      = 3'd4;

  typedef enum logic [2:0] {IDLE, SEND_INV, SEND_REPLY, SEND_FETCH, WAIT_WB} fsm_t;
  typedef enum logic [1:0] {DI, DS, DM} line_t;

  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];
  line_t             line_st   [LINES];
  logic [NPROC-1:0]  line_sh   [LINES];

  fsm_t state, state_n;
  logic              rsp_valid_n;
  logic [2:0]        rsp_op_n;
  logic [TAG_W-1:0]  rsp_tag_n;
  logic [NPROC-1:0]  rsp_dst_n;
  logic [DATA_W-1:0] rsp_data_n;

  logic [IDX_W-1:0]  pend_idx, pend_idx_n;
  logic [TAG_W-1:0]  pend_tag, pend_tag_n;
  logic [NPROC-1:0]  pend_dst, pend_dst_n;
  logic [NPROC-1:0]  pend_owner, pend_owner_n;
  logic              pend_rd, pend_rd_n;
  logic [DATA_W-1:0] pend_data, pend_data_n;

  logic              upd_en, upd_data_en;
  logic [IDX_W-1:0]  upd_idx;
  line_t             upd_st;
  logic [NPROC-1:0]  upd_sh;
  logic [DATA_W-1:0] upd_data;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [NPROC-1:0]  src_mask;
  line_t             cur_st;
  logic [NPROC-1:0]  cur_sh;
  logic [DATA_W-1:0] cur_data;
  logic              owner_is_src;
  logic              wb_match;
  logic              do_nack, do_reply, do_inv, do_fetch;

  // Tags are fixed at reset, but the lookup is a real associative compare.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!hit && line_tag[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign src_mask     = NPROC'(1) << req_src;
  assign cur_st       = line_st[hit_idx];
  assign cur_sh       = line_sh[hit_idx];
  assign cur_data     = line_data[hit_idx];
  assign owner_is_src = (cur_sh == src_mask);
  assign wb_match     = (req_op == OP_WB) && (req_tag == pend_tag) && (src_mask == pend_owner);
  assign busy         = (state != IDLE);

  always_comb begin
    state_n      = state;
    rsp_valid_n  = rsp_valid;
    rsp_op_n     = rsp_op;
    rsp_tag_n    = rsp_tag;
    rsp_dst_n    = rsp_dst;
    rsp_data_n   = rsp_data;
    pend_idx_n   = pend_idx;
    pend_tag_n   = pend_tag;
    pend_dst_n   = pend_dst;
    pend_owner_n = pend_owner;
    pend_rd_n    = pend_rd;
    pend_data_n  = pend_data;
    upd_en       = 1'b0;
    upd_data_en  = 1'b0;
    upd_idx      = hit_idx;
    upd_st       = cur_st;
    upd_sh       = cur_sh;
    upd_data     = req_data;
    req_ready    = 1'b0;
    do_nack      = 1'b0;
    do_reply     = 1'b0;
    do_inv       = 1'b0;
    do_fetch     = 1'b0;

    case (state)
      IDLE: begin
        // A pending NACK must drain before the next request is taken.
        req_ready = !rsp_valid;
        if (rsp_valid && rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_op_n    = '0;
          rsp_tag_n   = '0;
          rsp_dst_n   = '0;
          rsp_data_n  = '0;
        end
        if (req_valid && !rsp_valid) begin
          if (!hit || req_op == 2'd3) begin
            do_nack = 1'b1;
          end else begin
            case (req_op)
              OP_READ: begin
                if (cur_st == DM && !owner_is_src) begin
                  do_fetch = 1'b1;
                end else begin
                  do_reply = 1'b1;
                  if (cur_st != DM) begin
                    upd_en = 1'b1;
                    upd_st = DS;
                    upd_sh = (cur_st == DI) ? src_mask : (cur_sh | src_mask);
                  end
                end
              end
              OP_WRITE: begin
                if (cur_st == DM && !owner_is_src) begin
                  do_fetch = 1'b1;
                end else begin
                  if (cur_st == DS && (cur_sh & ~src_mask) != '0) do_inv = 1'b1;
                  else do_reply = 1'b1;
                  upd_en = 1'b1;
                  upd_st = DM;
                  upd_sh = src_mask;
                end
              end
              default: begin
                if (cur_st == DM && owner_is_src) begin
                  upd_en      = 1'b1;
                  upd_st      = DI;
                  upd_sh      = '0;
                  upd_data_en = 1'b1;
                end else begin
                  do_nack = 1'b1;
                end
              end
            endcase
          end
        end
      end
      SEND_INV: begin
        if (rsp_ready) begin
          rsp_op_n   = RSP_REPLY;
          rsp_dst_n  = pend_dst;
          rsp_data_n = pend_data;
          state_n    = SEND_REPLY;
        end
      end
      SEND_REPLY, SEND_FETCH: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_op_n    = '0;
          rsp_tag_n   = '0;
          rsp_dst_n   = '0;
          rsp_data_n  = '0;
          state_n     = (state == SEND_FETCH) ? WAIT_WB : IDLE;
        end
      end
      WAIT_WB: begin
        req_ready = wb_match;
        if (req_valid && wb_match) begin
          upd_en      = 1'b1;
          upd_data_en = 1'b1;
          upd_idx     = pend_idx;
          upd_st      = pend_rd ? DS : DM;
          upd_sh      = pend_rd ? (pend_owner | pend_dst) : pend_dst;
          rsp_valid_n = 1'b1;
          rsp_op_n    = RSP_REPLY;
          rsp_tag_n   = pend_tag;
          rsp_dst_n   = pend_dst;
          rsp_data_n  = req_data;
          state_n     = SEND_REPLY;
        end
      end
      default: state_n = IDLE;
    endcase

    // Response loaders shared by the IDLE decode above.
    if (do_nack || do_reply || do_inv || do_fetch) begin
      rsp_valid_n = 1'b1;
      rsp_tag_n   = req_tag;
      rsp_data_n  = '0;
    end
    if (do_nack) begin
      rsp_op_n  = RSP_NACK;
      rsp_dst_n = src_mask;
    end
    if (do_reply) begin
      rsp_op_n   = RSP_REPLY;
      rsp_dst_n  = src_mask;
      rsp_data_n = cur_data;
      state_n    = SEND_REPLY;
    end
    if (do_inv) begin
      rsp_op_n    = RSP_INV;
      rsp_dst_n   = cur_sh & ~src_mask;
      pend_dst_n  = src_mask;
      pend_data_n = cur_data;
      state_n     = SEND_INV;
    end
    if (do_fetch) begin
      rsp_op_n     = (req_op == OP_READ) ? RSP_FETCH : RSP_FETCH_INV;
      rsp_dst_n    = cur_sh;
      pend_idx_n   = hit_idx;
      pend_tag_n   = req_tag;
      pend_dst_n   = src_mask;
      pend_owner_n = cur_sh;
      pend_rd_n    = (req_op == OP_READ);
      state_n      = SEND_FETCH;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_tag    <= '0;
      rsp_dst    <= '0;
      rsp_data   <= '0;
      pend_idx   <= '0;
      pend_tag   <= '0;
      pend_dst   <= '0;
      pend_owner <= '0;
      pend_rd    <= 1'b0;
      pend_data  <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_tag[i]  <= TAG_W'(i);
        line_data[i] <= '0;
        line_st[i]   <= DI;
        line_sh[i]   <= '0;
      end
    end else begin
      state      <= state_n;
      rsp_valid  <= rsp_valid_n;
      rsp_op     <= rsp_op_n;
      rsp_tag    <= rsp_tag_n;
      rsp_dst    <= rsp_dst_n;
      rsp_data   <= rsp_data_n;
      pend_idx   <= pend_idx_n;
      pend_tag   <= pend_tag_n;
      pend_dst   <= pend_dst_n;
      pend_owner <= pend_owner_n;
      pend_rd    <= pend_rd_n;
      pend_data  <= pend_data_n;
      if (upd_en) begin
        line_st[upd_idx] <= upd_st;
        line_sh[upd_idx] <= upd_sh;
      end
      if (upd_data_en) line_data[upd_idx] <= upd_data;
    end
  end

endmodule

// File: tb/tb_dir_controller_p.sv
// Self-checking bench for dir_controller_p: constant vector table, directed multi-step
// sequences, then random traffic checked against a transaction-level directory model.
module tb_dir_controller_p;

  localparam int R_REPLY = 0, R_FETCH = 1, R_INV = 2, R_FINV = 3, R_NACK = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_tag = '0;
  logic [0:0]  req_src = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_op;
  logic [2:0]  rsp_tag;
  logic [1:0]  rsp_dst;
  logic [15:0] rsp_data;
  logic        busy;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    int op; int tag; int src; int data;
    bit has_rsp; int eop; int edst; int edata;
  } vec_t;
  vec_t tbl[13];

  // Reference directory: 0=DI 1=DS 2=DM, sharer mask, data.
  int mst[4];
  int msh[4];
  int mdat[4];

  dir_controller_p #(.NPROC(2), .LINES(4), .TAG_W(3), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_src(req_src), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_tag(rsp_tag), .rsp_dst(rsp_dst), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic modelInit();
    for (int i = 0; i < 4; i++) begin
      mst[i] = 0;
      msh[i] = 0;
      mdat[i] = 0;
    end
  endtask

  task automatic applyStimulus(input int op, input int tag, input int src, input int data);
    int n;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_tag   = 3'(tag);
    req_src   = 1'(src);
    req_data  = 16'(data);
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!req_ready) begin
      checkOutput("accept timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expectRsp(input string name, input int eop, input int etag, input int edst,
                           input int edata, input bit hs, input int dly);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!rsp_valid) begin
      checkOutput({name, " rsp timeout"}, 0, 1);
      return;
    end
    repeat (dly) begin
      @(posedge clock);
      #1;
    end
    checkOutput({name, " op"}, int'(rsp_op), eop);
    checkOutput({name, " tag"}, int'(rsp_tag), etag);
    checkOutput({name, " dst"}, int'(rsp_dst), edst);
    checkOutput({name, " data"}, int'(rsp_data), edata);
    if (hs) begin
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  // One random transaction, with expected responses derived from directory rules.
  task automatic randomTxn();
    int op, tag, src, d, s, owner, wd;
    op  = int'($urandom_range(0, 3));
    tag = int'($urandom_range(0, 7));
    src = int'($urandom_range(0, 1));
    d   = int'($urandom_range(0, 65535));
    s   = 1 << src;
    applyStimulus(op, tag, src, d);
    if (tag >= 4 || op == 3) begin
      expectRsp("rnd nack", R_NACK, tag, s, 0, 1, int'($urandom_range(0, 2)));
    end else if (op == 2) begin
      if (mst[tag] == 2 && msh[tag] == s) begin
        checkOutput("rnd wb silent", int'(rsp_valid), 0);
        mst[tag] = 0;
        msh[tag] = 0;
        mdat[tag] = d;
      end else begin
        expectRsp("rnd wb nack", R_NACK, tag, s, 0, 1, int'($urandom_range(0, 2)));
      end
    end else if (mst[tag] == 2 && msh[tag] != s) begin
      owner = (msh[tag] == 1) ? 0 : 1;
      expectRsp("rnd fetch", (op == 0) ? R_FETCH : R_FINV, tag, msh[tag], 0, 1,
                int'($urandom_range(0, 2)));
      wd = int'($urandom_range(0, 65535));
      applyStimulus(2, tag, owner, wd);
      expectRsp("rnd wb reply", R_REPLY, tag, s, wd, 1, int'($urandom_range(0, 2)));
      mdat[tag] = wd;
      if (op == 0) begin
        mst[tag] = 1;
        msh[tag] = msh[tag] | s;
      end else begin
        mst[tag] = 2;
        msh[tag] = s;
      end
    end else if (op == 1 && mst[tag] == 1 && (msh[tag] & ~s) != 0) begin
      expectRsp("rnd inv", R_INV, tag, msh[tag] & ~s, 0, 1, int'($urandom_range(0, 2)));
      expectRsp("rnd inv reply", R_REPLY, tag, s, mdat[tag], 1, int'($urandom_range(0, 2)));
      mst[tag] = 2;
      msh[tag] = s;
    end else begin
      expectRsp("rnd reply", R_REPLY, tag, s, mdat[tag], 1, int'($urandom_range(0, 2)));
      if (mst[tag] == 0) begin
        mst[tag] = (op == 0) ? 1 : 2;
        msh[tag] = s;
      end else if (mst[tag] == 1) begin
        if (op == 0) msh[tag] = msh[tag] | s;
        else begin
          mst[tag] = 2;
          msh[tag] = s;
        end
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0,      1, R_REPLY, 1, 0};
    tbl[1]  = '{0, 2, 0, 0,      1, R_REPLY, 1, 0};
    tbl[2]  = '{0, 2, 1, 0,      1, R_REPLY, 2, 0};
    tbl[3]  = '{0, 7, 1, 0,      1, R_NACK,  2, 0};
    tbl[4]  = '{3, 1, 0, 0,      1, R_NACK,  1, 0};
    tbl[5]  = '{2, 1, 0, 'h5555, 1, R_NACK,  1, 0};
    tbl[6]  = '{1, 3, 1, 0,      1, R_REPLY, 2, 0};
    tbl[7]  = '{2, 3, 0, 'h1111, 1, R_NACK,  1, 0};
    tbl[8]  = '{0, 3, 1, 0,      1, R_REPLY, 2, 0};
    tbl[9]  = '{2, 3, 1, 'hBEEF, 0, 0,       0, 0};
    tbl[10] = '{0, 3, 0, 0,      1, R_REPLY, 1, 'hBEEF};
    tbl[11] = '{2, 2, 0, 'h2222, 1, R_NACK,  1, 0};
    tbl[12] = '{0, 6, 0, 0,      1, R_NACK,  1, 0};

    doReset();
    checkOutput("reset req_ready", int'(req_ready), 1);
    checkOutput("reset rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset rsp_op", int'(rsp_op), 0);
    checkOutput("reset rsp_dst", int'(rsp_dst), 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].op, tbl[i].tag, tbl[i].src, tbl[i].data);
      if (tbl[i].has_rsp) begin
        expectRsp($sformatf("vec%0d", i), tbl[i].eop, tbl[i].tag, tbl[i].edst, tbl[i].edata, 1, 0);
      end else begin
        checkOutput($sformatf("vec%0d silent", i), int'(rsp_valid), 0);
        @(posedge clock);
        #1;
        checkOutput($sformatf("vec%0d still silent", i), int'(rsp_valid), 0);
      end
    end

    // Line 2 is DS {P0,P1}: P1 write invalidates P0 first.
    applyStimulus(1, 2, 1, 0);
    expectRsp("inv", R_INV, 2, 1, 0, 1, 1);
    expectRsp("inv reply", R_REPLY, 2, 2, 0, 1, 0);

    // Line 2 is DM owned by P1: P0 read forces a fetch, stray requests stall.
    applyStimulus(0, 2, 0, 0);
    expectRsp("fetch", R_FETCH, 2, 2, 0, 0, 0);
    checkOutput("fetch busy", int'(busy), 1);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    checkOutput("wait_wb busy", int'(busy), 1);
    req_valid = 1'b1;
    req_op = 2'd0;
    req_tag = 3'd1;
    req_src = 1'b0;
    #1;
    checkOutput("stray stall", int'(req_ready), 0);
    @(posedge clock);
    #1;
    checkOutput("stray stall 2", int'(req_ready), 0);
    req_valid = 1'b0;
    applyStimulus(2, 2, 1, 'h1234);
    expectRsp("fetch reply", R_REPLY, 2, 1, 'h1234, 1, 0);

    // Line 2 now DS {P0,P1} with data 0x1234.
    applyStimulus(1, 2, 1, 0);
    expectRsp("inv2", R_INV, 2, 1, 0, 1, 0);
    expectRsp("inv2 reply", R_REPLY, 2, 2, 'h1234, 1, 0);
    applyStimulus(1, 2, 0, 0);
    expectRsp("fetch_inv", R_FINV, 2, 2, 0, 1, 0);
    applyStimulus(2, 2, 1, 'hABCD);
    expectRsp("fetch_inv reply", R_REPLY, 2, 1, 'hABCD, 1, 0);
    applyStimulus(0, 2, 0, 0);
    expectRsp("owner re-miss", R_REPLY, 2, 1, 'hABCD, 1, 0);

    // NACK held while the consumer stalls.
    applyStimulus(0, 7, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("nack hold valid %0d", c), int'(rsp_valid), 1);
      checkOutput($sformatf("nack hold op %0d", c), int'(rsp_op), R_NACK);
      checkOutput($sformatf("nack hold dst %0d", c), int'(rsp_dst), 1);
      checkOutput($sformatf("nack hold tag %0d", c), int'(rsp_tag), 7);
      @(posedge clock);
      #1;
    end
    expectRsp("nack release", R_NACK, 7, 1, 0, 1, 0);

    // Reset while a FETCH is pending drops the response.
    applyStimulus(0, 2, 1, 0);
    expectRsp("fetch pre-reset", R_FETCH, 2, 1, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("abort rsp_valid", int'(rsp_valid), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort rsp_op", int'(rsp_op), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(0, 2, 1, 0);
    expectRsp("post-reset DI", R_REPLY, 2, 2, 0, 1, 0);

    // Reset while waiting for the owner's write-back.
    applyStimulus(1, 2, 0, 0);
    expectRsp("setup inv", R_INV, 2, 2, 0, 1, 0);
    expectRsp("setup reply", R_REPLY, 2, 1, 0, 1, 0);
    applyStimulus(0, 2, 1, 0);
    expectRsp("fetch wb-abort", R_FETCH, 2, 1, 0, 1, 0);
    checkOutput("wait_wb busy 2", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("wb abort busy", int'(busy), 0);
    checkOutput("wb abort rsp_valid", int'(rsp_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(0, 2, 1, 0);
    expectRsp("post-abort DI", R_REPLY, 2, 2, 0, 1, 0);

    doReset();
    modelInit();
    for (int t = 0; t < 150; t++) randomTxn();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
